// File: rtl/cache_def.sv
// Shared cache/memory types, arbiter state and owner encodings.
package cache_def;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_I    = 2'b01,
    OWN_D    = 2'b10
  } owner_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin pick: bit 0 is the i-port, bit 1 the d-port.
// last_grant_i = 1 means the d-port won the previous grant.
module rr_arbiter_2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  // One-hot grant; on a tie the port that did not win last time goes first.
  always_comb begin
    // NOTE: default assigned first so every path drives grant_o; no latch.
    grant_o = 2'b00;
    unique case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = last_grant_i ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates i_cache and d_cache miss traffic onto one backing memory.
// One transaction at a time: IDLE -> BUSY (request held) -> RESP (1 cycle).
module mem_arbiter
  import cache_def::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  mem_req_type  i_mem_req_i,
  input  mem_req_type  d_mem_req_i,
  output mem_data_type i_mem_data_o,
  output mem_data_type d_mem_data_o,
  output mem_req_type  mem_req_o,
  input  mem_data_type mem_data_i,
  output logic [1:0]   owner_o,
  output logic [31:0]  i_grants_o,
  output logic [31:0]  d_grants_o,
  output logic         timeout_o
);

  localparam logic [31:0] TimeoutLim = 32'(TIMEOUT_CYC);

  arb_state_e     state_q, state_d;
  owner_e         owner_q, owner_d;
  mem_req_type    req_q, req_d;
  cache_data_type i_data_q, i_data_d;
  cache_data_type d_data_q, d_data_d;
  logic           last_d_q, last_d_d;
  logic [31:0]    i_grants_q, i_grants_d;
  logic [31:0]    d_grants_q, d_grants_d;
  logic [31:0]    busy_cnt_q, busy_cnt_d;
  logic           timeout_q, timeout_d;
  logic [1:0]     grant;

  rr_arbiter_2 u_rr (
    .req_i        ({d_mem_req_i.valid, i_mem_req_i.valid}),
    .last_grant_i (last_d_q),
    .grant_o      (grant)
  );

  // Next-state logic: grant in IDLE, wait for memory in BUSY, one RESP cycle.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    req_d      = req_q;
    i_data_d   = i_data_q;
    d_data_d   = d_data_q;
    last_d_d   = last_d_q;
    i_grants_d = i_grants_q;
    d_grants_d = d_grants_q;
    busy_cnt_d = busy_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant[0]) begin
          state_d    = ST_BUSY;
          owner_d    = OWN_I;
          req_d      = i_mem_req_i;
          last_d_d   = 1'b0;
          i_grants_d = i_grants_q + 32'd1;
          busy_cnt_d = '0;
        end else if (grant[1]) begin
          state_d    = ST_BUSY;
          owner_d    = OWN_D;
          req_d      = d_mem_req_i;
          last_d_d   = 1'b1;
          d_grants_d = d_grants_q + 32'd1;
          busy_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (busy_cnt_q != TimeoutLim) busy_cnt_d = busy_cnt_q + 32'd1;
        if (mem_data_i.ready) begin
          state_d = ST_RESP;
          if (owner_q == OWN_I) i_data_d = mem_data_i.data;
          else                  d_data_d = mem_data_i.data;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    // Sticky: once the wait has been overdue, it stays flagged until reset.
    timeout_d = timeout_q | ((state_q == ST_BUSY) && (busy_cnt_d == TimeoutLim));
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      req_q      <= '0;
      // NOTE: the line buffers are reset too, so every output reads zero in reset.
      i_data_q   <= '0;
      d_data_q   <= '0;
      last_d_q   <= 1'b1;
      i_grants_q <= '0;
      d_grants_q <= '0;
      busy_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q    <= state_d;
      owner_q    <= owner_d;
      req_q      <= req_d;
      i_data_q   <= i_data_d;
      d_data_q   <= d_data_d;
      last_d_q   <= last_d_d;
      i_grants_q <= i_grants_d;
      d_grants_q <= d_grants_d;
      busy_cnt_q <= busy_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Output decode: request valid only in BUSY, ready only to the owner in RESP.
  always_comb begin
    mem_req_o          = req_q;
    mem_req_o.valid    = (state_q == ST_BUSY);
    i_mem_data_o.data  = i_data_q;
    i_mem_data_o.ready = (state_q == ST_RESP) && (owner_q == OWN_I);
    d_mem_data_o.data  = d_data_q;
    d_mem_data_o.ready = (state_q == ST_RESP) && (owner_q == OWN_D);
  end

  assign owner_o    = owner_q;
  assign i_grants_o = i_grants_q;
  assign d_grants_o = d_grants_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: scoreboard of expected transactions,
// a latency-programmable memory model, a vector table and corner sequences.
module tb_mem_arbiter;
  import cache_def::*;

  localparam int MAX_WAIT = 200;

  logic         clk_i;
  logic         rst_ni;
  mem_req_type  i_req, d_req, mem_req_o;
  mem_data_type i_mem_data_o, d_mem_data_o, mem_data_i;
  logic [1:0]   owner_o;
  logic [31:0]  i_grants_o, d_grants_o;
  logic         timeout_o;

  mem_arbiter #(.TIMEOUT_CYC(8)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .i_mem_req_i  (i_req),
    .d_mem_req_i  (d_req),
    .i_mem_data_o (i_mem_data_o),
    .d_mem_data_o (d_mem_data_o),
    .mem_req_o    (mem_req_o),
    .mem_data_i   (mem_data_i),
    .owner_o      (owner_o),
    .i_grants_o   (i_grants_o),
    .d_grants_o   (d_grants_o),
    .timeout_o    (timeout_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event not as required", name);
  endtask

  // Backing-memory contents as seen by the bench.
  function automatic logic [127:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return {16{8'hA5}};
    return {a ^ 32'h5A5A_0000, ~a, a, 32'hC0DE_0000 | {16'h0, a[15:0]}};
  endfunction

  // Scoreboard of expected transactions in service order.
  typedef struct {
    logic         port_d;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic         rw;
  } exp_t;
  exp_t sb_q[$];

  logic        last_d;
  logic [31:0] exp_i_grants, exp_d_grants;
  int          mem_lat;

  function automatic exp_t mk(input logic pd, input logic [31:0] a, input logic [127:0] w, input logic rw);
    exp_t e;
    e.port_d = pd; e.addr = a; e.wdata = w; e.rw = rw;
    return e;
  endfunction

  // Memory model: ready for one cycle in the mem_lat-th BUSY cycle (0 = never).
  initial begin
    int busy_n;
    busy_n = 0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o.valid) begin
        busy_n++;
        if (mem_lat != 0 && busy_n == mem_lat) begin
          mem_data_i.data  = mem_fn(mem_req_o.addr);
          mem_data_i.ready = 1'b1;
        end else begin
          mem_data_i = '0;
        end
      end else begin
        busy_n = 0;
        mem_data_i = '0;
      end
    end
  end

  // Monitor: compares the held request and every response against the scoreboard.
  logic prev_i_rdy = 1'b0, prev_d_rdy = 1'b0;
  always @(negedge clk_i) begin
    if (rst_ni && mem_req_o.valid) begin
      if (sb_q.size() == 0) fail("unexpected_busy");
      else begin
        check("busy_addr",  mem_req_o.addr, sb_q[0].addr);
        check("busy_wdata", mem_req_o.data, sb_q[0].wdata);
        check("busy_rw",    mem_req_o.rw,   sb_q[0].rw);
        check("busy_owner", owner_o, sb_q[0].port_d ? 2'b10 : 2'b01);
      end
    end
    if (prev_i_rdy) check("i_ready_one_cycle", i_mem_data_o.ready, 1'b0);
    if (prev_d_rdy) check("d_ready_one_cycle", d_mem_data_o.ready, 1'b0);
    if (i_mem_data_o.ready || d_mem_data_o.ready) begin
      check("single_ready", i_mem_data_o.ready & d_mem_data_o.ready, 1'b0);
      check("resp_req_valid", mem_req_o.valid, 1'b0);
      if (sb_q.size() == 0) fail("unexpected_ready");
      else begin
        check("ready_port", d_mem_data_o.ready, sb_q[0].port_d);
        check("ready_data", d_mem_data_o.ready ? d_mem_data_o.data : i_mem_data_o.data,
              mem_fn(sb_q[0].addr));
        void'(sb_q.pop_front());
      end
    end
    prev_i_rdy = i_mem_data_o.ready;
    prev_d_rdy = d_mem_data_o.ready;
  end

  task automatic do_reset();
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    i_req = '0;
    d_req = '0;
    sb_q.delete();
    last_d = 1'b1;
    exp_i_grants = 0;
    exp_d_grants = 0;
    mem_lat = 1;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Waits for each active port's ready and drops its valid; optional address
  // change on the d-port once its request is held.
  task automatic wait_ready(input bit iv, input bit dv, input bit perturb);
    bit i_done, d_done, done_p;
    int cyc;
    i_done = !iv; d_done = !dv; done_p = 0; cyc = 0;
    while (!(i_done && d_done) && cyc < MAX_WAIT) begin
      @(negedge clk_i);
      cyc++;
      if (perturb && !done_p && mem_req_o.valid) begin
        d_req.addr = 32'hDEAD_BEEC;
        d_req.data = '1;
        d_req.rw   = 1'b0;
        done_p = 1;
      end
      if (i_mem_data_o.ready) begin i_req.valid = 1'b0; i_done = 1; end
      if (d_mem_data_o.ready) begin d_req.valid = 1'b0; d_done = 1; end
    end
    if (!(i_done && d_done)) fail("ready_wait_expired");
  endtask

  task automatic run_txn(input logic iv, input logic [31:0] ia, input logic dv,
                         input logic [31:0] da, input logic drw, input logic [127:0] dwd,
                         input int lat, input bit perturb);
    exp_t ei, ed;
    mem_lat = lat;
    @(negedge clk_i);
    i_req.addr = ia; i_req.data = {4{ia}}; i_req.rw = 1'b0; i_req.valid = iv;
    d_req.addr = da; d_req.data = dwd;     d_req.rw = drw;  d_req.valid = dv;
    ei = mk(1'b0, ia, {4{ia}}, 1'b0);
    ed = mk(1'b1, da, dwd, drw);
    if (iv && dv) begin
      if (last_d) begin sb_q.push_back(ei); sb_q.push_back(ed); last_d = 1'b1; end
      else        begin sb_q.push_back(ed); sb_q.push_back(ei); last_d = 1'b0; end
    end else if (iv) begin sb_q.push_back(ei); last_d = 1'b0; end
    else if (dv)     begin sb_q.push_back(ed); last_d = 1'b1; end
    if (iv) exp_i_grants++;
    if (dv) exp_d_grants++;
    wait_ready(iv, dv, perturb);
    @(negedge clk_i);
    check("i_grants", i_grants_o, exp_i_grants);
    check("d_grants", d_grants_o, exp_d_grants);
    check("sb_drained", sb_q.size(), 0);
  endtask

  typedef struct {
    logic         iv;
    logic [31:0]  ia;
    logic         dv;
    logic [31:0]  da;
    logic         drw;
    logic [127:0] dwd;
    int           lat;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 32'h0000_0200, 1'b0, 32'h0,         1'b0, 128'h0,               1};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 32'h0000_0300, 1'b0, 128'h0,               3};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_0500, 1'b1, {4{32'hCAFE_F00D}},   2};
    vecs[3] = '{1'b1, 32'h0000_0600, 1'b1, 32'h0000_0700, 1'b0, 128'h0,               1};
    vecs[4] = '{1'b1, 32'h0000_0610, 1'b1, 32'h0000_0710, 1'b1, {8{16'hBEEF}},        2};
    vecs[5] = '{1'b1, 32'h0000_0800, 1'b0, 32'h0,         1'b0, 128'h0,               4};

    rst_ni = 1'b0;
    i_req = '0; d_req = '0;
    last_d = 1'b1; exp_i_grants = 0; exp_d_grants = 0; mem_lat = 1;
    #3;
    check("rst_owner",   owner_o, 2'b00);
    check("rst_mem_req", mem_req_o, '0);
    check("rst_i_data",  i_mem_data_o, '0);
    check("rst_d_data",  d_mem_data_o, '0);
    check("rst_grants",  {i_grants_o, d_grants_o}, '0);
    check("rst_timeout", timeout_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    // Idle with nothing valid: no request issued.
    repeat (3) @(negedge clk_i);
    check("idle_no_req", mem_req_o.valid, 1'b0);
    check("idle_owner",  owner_o, 2'b00);

    // Tie from reset: I (0x40) first, then D (0x80).
    run_txn(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 128'h0, 1, 1'b0);

    // I read of 0x100, memory ready in the 2nd BUSY cycle.
    do_reset();
    run_txn(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 128'h0, 2, 1'b0);
    check("i_line_a5", i_mem_data_o.data, {16{8'hA5}});
    check("d_not_ready", d_mem_data_o.ready, 1'b0);

    // Vector table.
    for (int k = 0; k < 6; k++)
      run_txn(vecs[k].iv, vecs[k].ia, vecs[k].dv, vecs[k].da, vecs[k].drw, vecs[k].dwd,
              vecs[k].lat, 1'b0);

    // D write, requester changes its inputs while BUSY.
    run_txn(1'b0, 32'h0, 1'b1, 32'h0000_0900, 1'b1,
            128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 4, 1'b1);

    // Back-to-back I requests held valid: IDLE dead cycle after each RESP.
    begin
      int n_rdy, rdy_cyc, cyc;
      mem_lat = 1;
      @(negedge clk_i);
      i_req.addr = 32'h0000_0A40; i_req.data = {4{32'h0000_0A40}}; i_req.rw = 1'b0;
      i_req.valid = 1'b1;
      repeat (3) sb_q.push_back(mk(1'b0, 32'h0000_0A40, {4{32'h0000_0A40}}, 1'b0));
      exp_i_grants += 3;
      last_d = 1'b0;
      n_rdy = 0; rdy_cyc = -10; cyc = 0;
      while (n_rdy < 3 && cyc < MAX_WAIT) begin
        @(negedge clk_i);
        cyc++;
        if (cyc == rdy_cyc + 1) begin
          check("b2b_idle_valid", mem_req_o.valid, 1'b0);
          check("b2b_idle_owner", owner_o, 2'b00);
        end
        if (cyc == rdy_cyc + 2) check("b2b_regrant", mem_req_o.valid, 1'b1);
        if (i_mem_data_o.ready) begin
          n_rdy++;
          rdy_cyc = cyc;
          if (n_rdy == 3) i_req.valid = 1'b0;
        end
      end
      if (n_rdy < 3) fail("b2b_wait_expired");
      @(negedge clk_i);
      check("b2b_i_grants", i_grants_o, exp_i_grants);
    end

    // Memory never ready: timeout after 8 BUSY cycles, then reset mid-BUSY.
    begin
      int cyc;
      mem_lat = 0;
      @(negedge clk_i);
      i_req.addr = 32'h0000_0C00; i_req.data = {4{32'h0000_0C00}}; i_req.rw = 1'b0;
      i_req.valid = 1'b1;
      sb_q.push_back(mk(1'b0, 32'h0000_0C00, {4{32'h0000_0C00}}, 1'b0));
      cyc = 0;
      do begin
        @(negedge clk_i);
        cyc++;
      end while (!mem_req_o.valid && cyc < MAX_WAIT);
      if (!mem_req_o.valid) fail("timeout_grant_expired");
      check("timeout_start", timeout_o, 1'b0);
      repeat (7) @(negedge clk_i);
      check("timeout_busy8", timeout_o, 1'b0);
      @(negedge clk_i);
      check("timeout_busy9", timeout_o, 1'b1);
      repeat (10) @(negedge clk_i);
      check("timeout_sticky", timeout_o, 1'b1);
      check("timeout_owner",  owner_o, 2'b01);
      check("timeout_waits",  mem_req_o.valid, 1'b1);

      #2 rst_ni = 1'b0;
      #1;
      check("mid_rst_owner",   owner_o, 2'b00);
      check("mid_rst_mem_req", mem_req_o, '0);
      check("mid_rst_i_data",  i_mem_data_o, '0);
      check("mid_rst_d_data",  d_mem_data_o, '0);
      check("mid_rst_grants",  {i_grants_o, d_grants_o}, '0);
      check("mid_rst_timeout", timeout_o, 1'b0);
      sb_q.delete();
      i_req = '0;
      d_req.addr = 32'h0000_0D00; d_req.data = {4{32'h0000_0D00}}; d_req.rw = 1'b0;
      d_req.valid = 1'b1;
      last_d = 1'b1; exp_i_grants = 0; exp_d_grants = 0; mem_lat = 1;
      @(negedge clk_i);
      sb_q.push_back(mk(1'b1, 32'h0000_0D00, {4{32'h0000_0D00}}, 1'b0));
      exp_d_grants = 1;
      last_d = 1'b1;
      rst_ni = 1'b1;
      wait_ready(1'b0, 1'b1, 1'b0);
      @(negedge clk_i);
      check("post_rst_i_grants", i_grants_o, exp_i_grants);
      check("post_rst_d_grants", d_grants_o, exp_d_grants);
      check("post_rst_timeout",  timeout_o, 1'b0);
    end

    repeat (2) @(negedge clk_i);
    check("final_sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, the BUSY cycle count after which the sticky timeout flag sets.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_mem_req_i, input, mem_req_type, the i_cache miss request: addr 32, data 128, rw 1, valid 1.
REQ-005 SHALL have port d_mem_req_i, input, mem_req_type, the d_cache miss/writeback request, same fields.
REQ-006 SHALL have port i_mem_data_o, output, mem_data_type, the line to the i_cache: data 128, ready 1.
REQ-007 SHALL have port d_mem_data_o, output, mem_data_type, the line to the d_cache, same fields.
REQ-008 SHALL have port mem_req_o, output, mem_req_type, the request to the shared backing memory.
REQ-009 SHALL have port mem_data_i, input, mem_data_type, the backing memory response; ready marks completion.
REQ-010 SHALL have port owner_o, output, 2, the current owner: 00 none, 01 I, 10 D.
REQ-011 SHALL have ports i_grants_o and d_grants_o, output, 32 each, per-port grant counters.
REQ-012 SHALL have port timeout_o, output, 1, the sticky flag for a memory response overdue.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-014 IDLE: no valid input -> SHALL stay in IDLE with mem_req_o.valid=0.
REQ-015 IDLE: exactly one valid -> SHALL grant that port, latch its addr/data/rw, go to BUSY next cycle.
REQ-016 IDLE: both valid -> SHALL grant the port not granted last (round-robin); last_grant resets to D, so I wins the first tie.
REQ-017 BUSY: mem_req_o SHALL present the latched request with valid=1; later changes on the requester's inputs are ignored.
REQ-018 BUSY: if mem_data_i.ready=1, SHALL register mem_data_i.data and go to RESP.
REQ-019 RESP, one cycle exactly: owner's mem_data_o SHALL show ready=1 and the registered data; then return to IDLE.
REQ-020 No new grant SHALL occur in RESP; the owner's still-high valid in RESP is ignored (one dead cycle).
REQ-021 Non-owner ready and mem_req_o.valid outside BUSY SHALL be 0; data outputs hold their last registered value.
REQ-022 Latency: memory ready in cycle N SHALL give requester ready in cycle N+1; minimum request-to-ready is 3 cycles for a 1-cycle memory.
REQ-023 A grant counter SHALL increment by 1 on the IDLE->BUSY transition for its port and wrap 0xFFFFFFFF->0.
REQ-024 A BUSY-cycle counter SHALL clear on entering BUSY and saturate at TIMEOUT_CYC.
REQ-025 When the BUSY-cycle counter reaches TIMEOUT_CYC, timeout_o SHALL set and stay set until reset; the FSM keeps waiting in BUSY.
REQ-026 owner_o SHALL be 00 in IDLE and the granted port in BUSY/RESP.

Reset
REQ-027 On rst_ni low, asynchronously: state=IDLE, owner_o=00, every mem_req_o/mem_data_o field=0, counters=0, timeout_o=0, last_grant=D.
REQ-028 Reset during BUSY SHALL abandon the transaction with no ready to either port; after release, requests arbitrate afresh.

Structure
REQ-029 mem_req_type, mem_data_type and cache_data_type (128-bit) SHALL come from the shared cache_def package.
REQ-030 The FSM state enum and the owner encoding SHALL be added to cache_def.
REQ-031 Round-robin pick SHALL live in one sub-module rr_arbiter_2 (combinational, inputs req[1:0] and last_grant, output one-hot grant).

Verification
REQ-032 I read only: addr 0x100, memory ready after 2 BUSY cycles with 0xA5A5...A5 -> i ready=1 for 1 cycle with that data; d ready=0; i_grants_o=1.
REQ-033 Both valid from reset: I addr 0x40, D addr 0x80 -> I served first, then D; mem_req_o.addr sequence is 0x40 then 0x80; both counters=1.
REQ-034 D write (rw=1, data 0x1234...), requester changes addr in BUSY -> mem_req_o holds the original addr/data/rw until ready.
REQ-035 Memory never ready, TIMEOUT_CYC=8 -> timeout_o rises after 8 BUSY cycles and stays high; owner_o unchanged.
REQ-036 rst_ni pulsed low mid-BUSY -> all outputs 0 immediately; after release, a pending D request is granted (I not requesting).
REQ-037 Back-to-back I requests held valid continuously -> one dead RESP cycle between grants; grant count matches completed transfers.
